// File: rtl/vec_mul_sequencer_if.sv
// Job-control and memory-side signal bundle for the vector multiply sequencer.
// The master side issues jobs and models the FIFO; the slave side is the sequencer.
interface vec_mul_sequencer_if #(
  parameter int ADDRESSSIZE = 10
);
  logic                   start;
  logic                   abort;
  logic                   reload_weights;
  logic [ADDRESSSIZE-1:0] num_vecs;
  logic [ADDRESSSIZE-1:0] src_base;
  logic [ADDRESSSIZE-1:0] dst_base;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   weight_reload;
  logic                   ub_read_en;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   res_write_en;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, reload_weights, num_vecs, src_base, dst_base, fifo_empty,
    input  fifo_read_enable, weight_reload, ub_read_en, ub_address,
           res_write_en, res_address, busy, done
  );

  modport slave (
    input  start, abort, reload_weights, num_vecs, src_base, dst_base, fifo_empty,
    output fifo_read_enable, weight_reload, ub_read_en, ub_address,
           res_write_en, res_address, busy, done
  );
endinterface

// File: rtl/vec_mul_sequencer.sv
// Sequencer for a systolic vector multiply: optional weight load from the
// weight FIFO, streaming of input vectors from the unified buffer, and
// write-back of results after a fixed pipeline latency.
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int PIPE_LATENCY = 34,
  parameter int WLOAD_CYCLES = 32
) (
  input logic clk,
  input logic rstn,
  vec_mul_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_FIFO = 3'd1;
  localparam logic [2:0] POP       = 3'd2;
  localparam logic [2:0] WRELOAD   = 3'd3;
  localparam logic [2:0] STREAM    = 3'd4;
  localparam logic [2:0] DRAIN     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam int AW = ADDRESSSIZE;

  logic [2:0]              state_reg, state_next;
  logic [AW-1:0]           num_reg, src_reg;
  logic [AW-1:0]           rd_cnt_reg, wr_cnt_reg;
  logic [31:0]             wl_cnt_reg;
  logic [AW-1:0]           ub_addr_reg, wr_addr_reg, res_last_reg;
  logic [PIPE_LATENCY-1:0] vld_reg;

  logic accept;
  logic stream_enter;
  logic stream_stay;
  logic res_we;
  logic rd_last;
  logic wl_last;

  assign accept       = (state_reg == IDLE) && bus.start && !bus.abort;
  assign stream_enter = (state_next == STREAM) && (state_reg != STREAM);
  assign stream_stay  = (state_reg == STREAM) && (state_next == STREAM);
  assign res_we       = vld_reg[PIPE_LATENCY-1];
  assign rd_last      = (rd_cnt_reg == num_reg - AW'(1));
  assign wl_last      = (wl_cnt_reg == 32'(WLOAD_CYCLES - 1));

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.reload_weights)             state_next = WAIT_FIFO;
          else if (bus.num_vecs == '0)        state_next = DONE;
          else                                state_next = STREAM;
        end
      end
      WAIT_FIFO: if (!bus.fifo_empty)         state_next = POP;
      POP:                                    state_next = WRELOAD;
      WRELOAD: begin
        if (wl_last)                          state_next = (num_reg == '0) ? DONE : STREAM;
      end
      STREAM: if (rd_last)                    state_next = DRAIN;
      DRAIN: begin
        if (res_we && (wr_cnt_reg == num_reg - AW'(1))) state_next = DONE;
      end
      DONE:                                   state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Job parameters captured once at acceptance and held for the whole job
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_reg <= '0;
      src_reg <= '0;
    end else if (accept) begin
      num_reg <= bus.num_vecs;
      src_reg <= bus.src_base;
    end
  end

  // Phase counters: weight-load length, reads issued, writes retired
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wl_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else if (bus.abort || accept) begin
      wl_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      wl_cnt_reg <= (state_reg == WRELOAD) ? wl_cnt_reg + 32'd1 : 32'd0;
      rd_cnt_reg <= stream_stay ? rd_cnt_reg + AW'(1) : '0;
      if (res_we) wr_cnt_reg <= wr_cnt_reg + AW'(1);
    end
  end

  // Read address: loaded on STREAM entry, advanced per read, held otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             ub_addr_reg <= '0;
    else if (stream_enter) ub_addr_reg <= (state_reg == IDLE) ? bus.src_base : src_reg;
    else if (stream_stay)  ub_addr_reg <= ub_addr_reg + AW'(1);
  end

  // Write address: next-write pointer plus the last address actually written
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr_reg  <= '0;
      res_last_reg <= '0;
    end else if (accept) begin
      wr_addr_reg  <= bus.dst_base;
    end else if (res_we) begin
      wr_addr_reg  <= wr_addr_reg + AW'(1);
      res_last_reg <= wr_addr_reg;
    end
  end

  // Valid pipeline mirroring the multiplier latency; flushed on abort
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || bus.abort) begin
      vld_reg <= '0;
    end else begin
      for (int i = PIPE_LATENCY - 1; i > 0; i--) vld_reg[i] <= vld_reg[i-1];
      vld_reg[0] <= bus.ub_read_en;
    end
  end

  assign bus.fifo_read_enable = (state_reg == POP);
  assign bus.weight_reload    = (state_reg == WRELOAD);
  assign bus.ub_read_en       = (state_reg == STREAM);
  assign bus.ub_address       = ub_addr_reg;
  assign bus.res_write_en     = res_we;
  assign bus.res_address      = res_we ? wr_addr_reg : res_last_reg;
  assign bus.busy             = (state_reg != IDLE);
  assign bus.done             = (state_reg == DONE);

endmodule
